// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the data-memory arbiter between the MIPS core
// and the host/debug port.
package mips_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BURST_MAX  = 4;
  localparam int LEN_W          = $clog2(DEF_BURST_MAX);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core's
// load/store path and a host port that issues single writes or read bursts.
module dmem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_MAX  = DEF_BURST_MAX
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_mem_read,
  input  logic                         cpu_mem_write,
  input  logic [ADDR_WIDTH-1:0]        cpu_addr,
  input  logic [DATA_WIDTH-1:0]        cpu_wdata,
  output logic [DATA_WIDTH-1:0]        cpu_rdata,
  output logic                         cpu_stall,
  input  logic                         host_req_valid,
  output logic                         host_req_ready,
  input  logic                         host_req_write,
  input  logic [ADDR_WIDTH-1:0]        host_req_addr,
  input  logic [$clog2(BURST_MAX)-1:0] host_req_len,
  input  logic [DATA_WIDTH-1:0]        host_req_wdata,
  output logic                         host_rsp_valid,
  output logic [DATA_WIDTH-1:0]        host_rsp_data,
  output logic                         host_rsp_last,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic                         mem_write,
  output logic                         mem_read,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int BLEN_W = $clog2(BURST_MAX);

  arb_state_e              state_q, state_d;
  logic [BLEN_W-1:0]       beat_q, beat_d;
  logic [BLEN_W-1:0]       len_q, len_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    last_host_q, last_host_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_last_q, rsp_last_d;

  logic cpu_access;
  logic host_win;
  logic cpu_win;

  assign cpu_access = cpu_mem_read | cpu_mem_write;
  assign cpu_rdata  = mem_rdata;

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    len_d          = len_q;
    base_d         = base_q;
    last_host_d    = last_host_q;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = '0;
    rsp_last_d     = 1'b0;
    host_win       = 1'b0;
    cpu_win        = 1'b0;
    host_req_ready = 1'b0;
    cpu_stall      = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The host is refused only when the core also wants the memory and
        // the host had the previous grant; ready never looks at valid.
        host_req_ready = !(cpu_access && last_host_q);
        host_win       = host_req_valid && host_req_ready;
        cpu_win        = cpu_access && !host_win;
        cpu_stall      = cpu_access && host_win;

        if (host_win) begin
          mem_addr    = host_req_addr;
          mem_write   = host_req_write;
          mem_read    = !host_req_write;
          mem_wdata   = host_req_write ? host_req_wdata : '0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = host_req_write ? '0 : mem_rdata;
          rsp_last_d  = host_req_write || (host_req_len == '0);
          if (!host_req_write && (host_req_len != '0)) begin
            state_d = ST_BURST;
            beat_d  = BLEN_W'(1);
            len_d   = host_req_len;
            base_d  = host_req_addr;
          end else begin
            last_host_d = 1'b1;
          end
        end else if (cpu_win) begin
          // A simultaneous read+write from the core is treated as a write.
          mem_addr    = cpu_addr;
          mem_write   = cpu_mem_write;
          mem_read    = !cpu_mem_write;
          mem_wdata   = cpu_mem_write ? cpu_wdata : '0;
          last_host_d = 1'b0;
        end
      end

      ST_BURST: begin
        cpu_stall   = cpu_access;
        mem_addr    = base_q + ADDR_WIDTH'(beat_q);
        mem_read    = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_rdata;
        rsp_last_d  = (beat_q == len_q);
        if (beat_q == len_q) begin
          state_d     = ST_IDLE;
          beat_d      = '0;
          last_host_d = 1'b1;
        end else begin
          beat_d = beat_q + BLEN_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      base_q  <= base_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_host_q <= 1'b0;
    end else begin
      last_host_q <= last_host_d;
    end
  end

  // Reset drops any beat in flight, so an aborted burst never reports last.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign host_rsp_valid = rsp_valid_q;
  assign host_rsp_data  = rsp_data_q;
  assign host_rsp_last  = rsp_last_q;

endmodule
